// File: rtl/scan_cycle_controller.sv
// -----------------------------------------------------------------------------
// scan_cycle_controller
//
// PLC scan-cycle sequencer. Each scan runs three phases: the input points are
// written into the image memory, the CPUs execute in parallel, and the output
// points are written from the image memory. The block drives the image-memory
// write strobes and the common START line to all bit and word CPUs. A watchdog
// bounds the execute phase. Single-step mode runs one scan per STEP pulse.
// A free-running counter counts completed scans.
//
// State table (encoding is visible on state_o)
//   state        | meaning
//   -------------+-------------------------------------------------------------
//   IDLE     00  | waiting for RUN (and STEP in step mode); parked on WDT fault
//   EXEC     01  | START high, waiting for every enabled core to report DONE
//   IN_SCAN  10  | input points 0..N_IN-1 written to the image memory
//   OUT_SCAN 11  | output points 0..N_OUT-1 written to the output latches
//
// Ports
//   clk_i        system clock, rising edge
//   clr_i        synchronous active-high clear, aborts any scan in progress
//   run_i        level, 1 = scanning enabled
//   step_mode_i  1 = one scan per step_i pulse
//   step_i       one-cycle scan request, used only in IDLE with step_mode_i=1
//   core_en_i    per-core enable; a disabled core is treated as done
//   done_i       per-core completion flags
//   wdt_limit_i  maximum EXEC cycles, 0 disables the watchdog
//   state_o      current state (see table)
//   count_o      point index during IN_SCAN/OUT_SCAN, 0 otherwise
//   start_o      high throughout EXEC
//   in_we_o      image-memory input write strobe (IN_SCAN)
//   out_we_o     output latch write strobe (OUT_SCAN)
//   cycle_end_o  one-cycle pulse on the last OUT_SCAN cycle
//   wdt_err_o    sticky watchdog fault, cleared only by clr_i
//   cycles_o     completed-scan counter, wraps 16'hFFFF -> 0
// -----------------------------------------------------------------------------
module scan_cycle_controller #(
    parameter int unsigned N_CORES = 3,
    parameter int unsigned N_IN    = 16,
    parameter int unsigned N_OUT   = 16,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned WDT_W   = 16
) (
    input  logic               clk_i,
    input  logic               clr_i,
    input  logic               run_i,
    input  logic               step_mode_i,
    input  logic               step_i,
    input  logic [N_CORES-1:0] core_en_i,
    input  logic [N_CORES-1:0] done_i,
    input  logic [WDT_W-1:0]   wdt_limit_i,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               start_o,
    output logic               in_we_o,
    output logic               out_we_o,
    output logic               cycle_end_o,
    output logic               wdt_err_o,
    output logic [15:0]        cycles_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EXEC     = 2'b01,
        ST_IN_SCAN  = 2'b10,
        ST_OUT_SCAN = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [WDT_W-1:0]   wdt_q,     wdt_d;
    logic               wdt_err_q, wdt_err_d;
    logic [15:0]        cycles_q,  cycles_d;

    logic               all_done;
    logic               start_req;
    logic               wdt_expire;

    // A masked-off core never holds up the execute phase.
    assign all_done = &(done_i | ~core_en_i);

    // STEP only matters while waiting in IDLE; it is never latched.
    assign start_req = run_i && !wdt_err_q && (!step_mode_i || step_i);

    // Counter starts at 0 on the first EXEC cycle, so matching LIMIT-1 gives
    // exactly LIMIT EXEC cycles before the fault.
    assign wdt_expire = (wdt_limit_i != '0) && (wdt_q == (wdt_limit_i - WDT_ONE));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            wdt_q     <= '0;
            wdt_err_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wdt_q     <= wdt_d;
            wdt_err_q <= wdt_err_d;
            cycles_q  <= cycles_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wdt_d     = wdt_q;
        wdt_err_d = wdt_err_q;
        cycles_d  = cycles_q;

        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (start_req) begin
                    state_d = ST_IN_SCAN;
                end
            end

            ST_IN_SCAN: begin
                if (count_q == IN_LAST) begin
                    state_d = ST_EXEC;
                    count_d = '0;
                    wdt_d   = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end

            ST_EXEC: begin
                count_d = '0;
                // Completion is checked first so a late DONE still wins
                // against a watchdog expiring in the same cycle.
                if (all_done) begin
                    state_d = ST_OUT_SCAN;
                end else if (wdt_expire) begin
                    state_d   = ST_IDLE;
                    wdt_err_d = 1'b1;
                end else begin
                    wdt_d = wdt_q + WDT_ONE;
                end
            end

            ST_OUT_SCAN: begin
                if (count_q == OUT_LAST) begin
                    count_d  = '0;
                    cycles_d = cycles_q + 16'd1;
                    // Back-to-back scans only in free-running mode; a RUN drop
                    // anywhere in the scan is honoured here, at scan end.
                    if (run_i && !step_mode_i) begin
                        state_d = ST_IN_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: registered state and count only, never inputs
    // ------------------------------------------------------------------
    always_comb begin
        state_o     = state_q;
        count_o     = count_q;
        start_o     = (state_q == ST_EXEC);
        in_we_o     = (state_q == ST_IN_SCAN);
        out_we_o    = (state_q == ST_OUT_SCAN);
        cycle_end_o = (state_q == ST_OUT_SCAN) && (count_q == OUT_LAST);
        wdt_err_o   = wdt_err_q;
        cycles_o    = cycles_q;
    end

endmodule
